// File: rtl/dcache_controller_pkg.sv
// Shared pipeline definitions for the data cache: FSM encoding and default geometry.
package dcache_controller_pkg;

  localparam int DEF_NUM_LINES      = 4;
  localparam int DEF_WORDS_PER_LINE = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2
  } dc_state_e;

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped tag/valid/dirty/data storage with one word write port and one
// full-line write port; reads are combinational so hit detection is same-cycle.
module dcache_array
  import dcache_controller_pkg::*;
#(
  parameter int NUM_LINES      = DEF_NUM_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  localparam int OFF_W  = $clog2(WORDS_PER_LINE),
  localparam int IDX_W  = $clog2(NUM_LINES),
  localparam int TAG_W  = 30 - OFF_W - IDX_W,
  localparam int LINE_W = 32 * WORDS_PER_LINE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_index_i,
  output logic              rd_valid_o,
  output logic              rd_dirty_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_line_o,
  input  logic              ww_en_i,
  input  logic [IDX_W-1:0]  ww_index_i,
  input  logic [OFF_W-1:0]  ww_off_i,
  input  logic [31:0]       ww_data_i,
  input  logic              lw_en_i,
  input  logic [IDX_W-1:0]  lw_index_i,
  input  logic [TAG_W-1:0]  lw_tag_i,
  input  logic [LINE_W-1:0] lw_data_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
      logic lw_sel;
      logic ww_sel;
      assign lw_sel = lw_en_i && (lw_index_i == IDX_W'(gi));
      assign ww_sel = ww_en_i && (ww_index_i == IDX_W'(gi));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_q[gi] <= 1'b0;
          dirty_q[gi] <= 1'b0;
        end else if (lw_sel) begin
          valid_q[gi] <= 1'b1;
          dirty_q[gi] <= 1'b0;
        end else if (ww_sel) begin
          dirty_q[gi] <= 1'b1;
        end
      end

      // Tag and data contents are meaningless until valid is set, so no reset.
      always_ff @(posedge clk) begin
        if (lw_sel) begin
          tag_q[gi]  <= lw_tag_i;
          data_q[gi] <= lw_data_i;
        end else if (ww_sel) begin
          data_q[gi][{ww_off_i, 5'd0} +: 32] <= ww_data_i;
        end
      end
    end
  endgenerate

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_dirty_o = dirty_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_line_o  = data_q[rd_index_i];

endmodule

// File: rtl/dcache_controller.sv
// Write-back, write-allocate direct-mapped data cache controller. Misses stall the
// pipeline while a dirty victim is written back and the requested line is refilled.
module dcache_controller
  import dcache_controller_pkg::*;
#(
  parameter int NUM_LINES      = DEF_NUM_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        MemReadM,
  input  logic                        MemWriteM,
  input  logic [31:0]                 AddrM,
  input  logic [31:0]                 WriteDataM,
  output logic [31:0]                 ReadDataM,
  output logic                        CacheStall,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [31:0]                 mem_addr,
  output logic [32*WORDS_PER_LINE-1:0] mem_wdata,
  input  logic [32*WORDS_PER_LINE-1:0] mem_rdata,
  input  logic                        mem_ready
);

  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = 30 - OFF_W - IDX_W;
  localparam int LINE_W = 32 * WORDS_PER_LINE;

  dc_state_e state_q, state_d;

  logic [OFF_W-1:0]  offset;
  logic [IDX_W-1:0]  index;
  logic [TAG_W-1:0]  tag;
  logic              access;
  logic              hit;
  logic              unused_addr_lsb;

  logic              rd_valid;
  logic              rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic [31:0]       rd_word;
  logic              ww_en;
  logic              lw_en;

  assign offset          = AddrM[OFF_W+1:2];
  assign index           = AddrM[OFF_W+2 +: IDX_W];
  assign tag             = AddrM[31 -: TAG_W];
  assign unused_addr_lsb = ^AddrM[1:0];

  assign access  = MemReadM | MemWriteM;
  assign hit     = rd_valid && (rd_tag == tag);
  assign rd_word = rd_line[{offset, 5'd0} +: 32];

  dcache_array #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_index_i (index),
    .rd_valid_o (rd_valid),
    .rd_dirty_o (rd_dirty),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .ww_en_i    (ww_en),
    .ww_index_i (index),
    .ww_off_i   (offset),
    .ww_data_i  (WriteDataM),
    .lw_en_i    (lw_en),
    .lw_index_i (index),
    .lw_tag_i   (tag),
    .lw_data_i  (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (access && !hit) state_d = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_REFILL;
      end
      ST_WRITEBACK: if (mem_ready) state_d = ST_REFILL;
      ST_REFILL:    if (mem_ready) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // AddrM is held by the stalled pipeline, so the refill address stays stable.
  always_comb begin
    CacheStall = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    ReadDataM  = '0;
    ww_en      = 1'b0;
    lw_en      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        CacheStall = access && !hit;
        ww_en      = MemWriteM && hit;
        if (MemReadM && !MemWriteM && hit) ReadDataM = rd_word;
      end
      ST_WRITEBACK: begin
        CacheStall = 1'b1;
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = {rd_tag, index, {(OFF_W+2){1'b0}}};
        mem_wdata  = rd_line;
      end
      ST_REFILL: begin
        CacheStall = 1'b1;
        mem_req    = 1'b1;
        mem_addr   = {tag, index, {(OFF_W+2){1'b0}}};
        lw_en      = mem_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed and random traffic against a line-level cache model backed by a word memory.
module tb_dcache_controller;

  localparam int NL   = 4;
  localparam int WPL  = 4;
  localparam int LW   = 32 * WPL;
  localparam int OFFB = 4;   // byte offset bits within a line
  localparam int IDXB = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          MemReadM, MemWriteM;
  logic [31:0]   AddrM, WriteDataM, ReadDataM;
  logic          CacheStall, mem_req, mem_we, mem_ready;
  logic [31:0]   mem_addr;
  logic [LW-1:0] mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  bit          m_valid [NL];
  bit          m_dirty [NL];
  int unsigned m_tag   [NL];
  logic [31:0] m_data  [NL][WPL];
  logic [31:0] mem     [int unsigned];

  always #5 clk = ~clk;

  dcache_controller #(.NUM_LINES(NL), .WORDS_PER_LINE(WPL)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .AddrM      (AddrM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .CacheStall (CacheStall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  task automatic chk(input string name, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input int unsigned wa);
    if (mem.exists(wa)) return mem[wa];
    return (wa * 32'h9E37_79B9) ^ 32'h0000_1234;
  endfunction

  function automatic logic [LW-1:0] model_line(input int idx);
    logic [LW-1:0] l;
    for (int w = 0; w < WPL; w++) l[w*32 +: 32] = m_data[idx][w];
    return l;
  endfunction

  function automatic logic [LW-1:0] mem_line(input logic [31:0] la);
    logic [LW-1:0] l;
    for (int w = 0; w < WPL; w++) l[w*32 +: 32] = mem_rd((la >> 2) + w);
    return l;
  endfunction

  // Memory side of one transfer; entered and left at posedge+1.
  task automatic serve(input bit we, input logic [31:0] la, input logic [LW-1:0] wline, input int dly);
    for (int i = 0; i <= dly; i++) begin
      if (i == dly) begin
        mem_ready = 1'b1;
        mem_rdata = we ? {LW{1'b1}} : mem_line(la);
      end
      @(negedge clk);
      chk("mem_req",    mem_req, 1);
      chk("mem_we",     mem_we, we);
      chk("mem_addr",   mem_addr, la);
      chk("busy_stall", CacheStall, 1);
      chk("busy_rdata", ReadDataM, 0);
      if (we) chk("mem_wdata", mem_wdata, wline);
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  // One pipeline access, held until it completes; entered and left at posedge+1.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input int dly);
    int          idx, off;
    int unsigned tg;
    logic [31:0] la, va;
    MemReadM = rd; MemWriteM = wr; AddrM = addr; WriteDataM = data;
    off = (addr >> 2) % WPL;
    idx = (addr >> OFFB) % NL;
    tg  = addr >> (OFFB + IDXB);
    la  = (tg << (OFFB + IDXB)) | (idx << OFFB);
    @(negedge clk);
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      chk("miss_stall", CacheStall, 1);
      chk("miss_rdata", ReadDataM, 0);
      @(posedge clk); #1;
      if (m_valid[idx] && m_dirty[idx]) begin
        va = (m_tag[idx] << (OFFB + IDXB)) | (idx << OFFB);
        serve(1'b1, va, model_line(idx), dly);
        for (int w = 0; w < WPL; w++) mem[(va >> 2) + w] = m_data[idx][w];
      end
      serve(1'b0, la, '0, dly);
      for (int w = 0; w < WPL; w++) m_data[idx][w] = mem_rd((la >> 2) + w);
      m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0; m_tag[idx] = tg;
      @(negedge clk);
    end
    chk("hit_stall", CacheStall, 0);
    chk("hit_req",   mem_req, 0);
    chk("hit_rdata", ReadDataM, (rd && !wr) ? m_data[idx][off] : 32'h0);
    @(posedge clk); #1;
    if (wr) begin
      m_data[idx][off] = data;
      m_dirty[idx] = 1'b1;
    end
    MemReadM = 0; MemWriteM = 0; AddrM = 0; WriteDataM = 0;
  endtask

  initial begin
    rst = 0; MemReadM = 0; MemWriteM = 0; AddrM = 0; WriteDataM = 0;
    mem_ready = 0; mem_rdata = '0;
    for (int i = 0; i < NL; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = 0; end
    mem[32'h40 >> 2] = 32'd1; mem[(32'h40 >> 2) + 1] = 32'd2;
    mem[(32'h40 >> 2) + 2] = 32'd3; mem[(32'h40 >> 2) + 3] = 32'd4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", CacheStall, 0);
    chk("rst_req",   mem_req, 0);
    chk("rst_we",    mem_we, 0);
    chk("rst_addr",  mem_addr, 0);
    chk("rst_rdata", ReadDataM, 0);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;

    access(1, 0, 32'h40, 0, 0);                  // cold refill {4,3,2,1}, word0 = 1
    access(1, 0, 32'h4C, 0, 0);
    access(0, 1, 32'h44, 32'hDEAD_BEEF, 0);
    access(1, 0, 32'h44, 0, 0);
    access(1, 0, 32'h80, 0, 0);                  // write-back of 0x40 then refill 0x80
    access(1, 0, 32'h84, 0, 5);
    access(1, 0, 32'h44, 0, 5);                  // long-latency refill, line now carries DEADBEEF
    access(1, 1, 32'h48, 32'h5, 0);              // both strobes behave as a store
    access(1, 0, 32'h48, 0, 0);

    // Reset in the middle of a refill; a late mem_ready must not install a line.
    MemReadM = 1; AddrM = 32'h50;
    @(negedge clk);
    chk("r39_miss", CacheStall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("r39_req",  mem_req, 1);
    chk("r39_addr", mem_addr, 32'h50);
    #1 rst = 0;
    #1 chk("r39_rst_req", mem_req, 0);
    MemReadM = 0; AddrM = 0;
    #1;
    chk("r39_rst_stall", CacheStall, 0);
    chk("r39_rst_addr",  mem_addr, 0);
    chk("r39_rst_we",    mem_we, 0);
    @(posedge clk); #1 rst = 1;
    for (int i = 0; i < NL; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
    mem_ready = 1; mem_rdata = {LW{1'b1}};
    @(posedge clk); #1 mem_ready = 0; mem_rdata = '0;
    @(negedge clk);
    chk("r39_idle_req",   mem_req, 0);
    chk("r39_idle_stall", CacheStall, 0);
    @(posedge clk); #1;
    access(1, 0, 32'h40, 0, 0);                  // must miss again
    access(1, 0, 32'h50, 0, 1);

    for (int t = 0; t < 80; t++) begin
      int unsigned op, a;
      op = $urandom_range(3);
      a  = ($urandom_range(3) << (OFFB + IDXB)) | ($urandom_range(NL - 1) << OFFB)
         | ($urandom_range(WPL - 1) << 2);
      access(op < 2 ? 1'b1 : (op == 3), op >= 2, a, $urandom, $urandom_range(3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 SHALL have parameter NUM_LINES, default 4, number of direct-mapped lines (power of 2).
REQ-002 SHALL have parameter WORDS_PER_LINE, default 4, 32-bit words per line (power of 2).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port MemReadM  input  1  load access in Memory stage.
REQ-006 SHALL have port MemWriteM  input  1  store access in Memory stage.
REQ-007 SHALL have port AddrM  input  32  byte address (word aligned).
REQ-008 SHALL have port WriteDataM  input  32  store data.
REQ-009 SHALL have port ReadDataM  output  32  load data, valid on a hit.
REQ-010 SHALL have port CacheStall  output  1  pipeline stall request, consumed by the hazard unit.
REQ-011 SHALL have port mem_req  output  1  memory request, held until mem_ready.
REQ-012 SHALL have port mem_we  output  1  1 = line write-back, 0 = line refill.
REQ-013 SHALL have port mem_addr  output  32  line-aligned byte address.
REQ-014 SHALL have port mem_wdata  output  32*WORDS_PER_LINE  write-back line, word 0 in LSBs.
REQ-015 SHALL have port mem_rdata  input  32*WORDS_PER_LINE  refill line, word 0 in LSBs.
REQ-016 SHALL have port mem_ready  input  1  one-cycle completion pulse from memory.

Function
REQ-017 Address split SHALL be: word offset AddrM[OFF+1:2], index next log2(NUM_LINES) bits, tag = remaining upper bits; OFF = log2(WORDS_PER_LINE).
REQ-018 Hit SHALL be combinational: valid[index] & tag match, with access = MemReadM | MemWriteM.
REQ-019 State machine SHALL have states IDLE, WRITEBACK, REFILL.
REQ-020 IDLE, access & hit: CacheStall = 0; load returns word combinationally on ReadDataM; store writes word and sets dirty[index] at next edge.
REQ-021 IDLE, access & miss: CacheStall = 1 in the same cycle; next state WRITEBACK if valid & dirty, else REFILL.
REQ-022 WRITEBACK: mem_req=1, mem_we=1, mem_addr = {stored tag, index, 0}, mem_wdata = stored line; on mem_ready go to REFILL.
REQ-023 REFILL: mem_req=1, mem_we=0, mem_addr = {AddrM tag, index, 0}; on mem_ready write mem_rdata into line, set valid, clear dirty, tag := AddrM tag, go to IDLE.
REQ-024 CacheStall SHALL be 1 in every WRITEBACK and REFILL cycle, and in the IDLE cycle after refill SHALL follow REQ-020 (access now hits, stall drops).
REQ-025 mem_addr, mem_we, mem_wdata SHALL be stable while mem_req=1; mem_req SHALL be 0 in IDLE.
REQ-026 Write-allocate: store miss SHALL refill, then merge on the hit cycle (REQ-020).
REQ-027 MemReadM and MemWriteM both 1 SHALL be treated as a store.
REQ-028 mem_ready while in IDLE SHALL be ignored.
REQ-029 ReadDataM SHALL be 0 when no load hit is in progress.

Reset
REQ-030 rst low SHALL asynchronously force state IDLE and clear all valid and dirty bits; data/tag arrays need no reset.
REQ-031 Reset-time outputs: CacheStall=0, mem_req=0, mem_we=0, mem_addr=0, ReadDataM=0.
REQ-032 Reset mid-WRITEBACK/REFILL SHALL abandon the transfer; no line SHALL be updated by a mem_ready arriving after reset release while in IDLE.

Structure
REQ-033 State encoding and default NUM_LINES/WORDS_PER_LINE constants SHALL live in the shared pipeline package.
REQ-034 One sub-module, dcache_array (tag/valid/dirty/data storage with word write and line write ports), SHALL be used; the FSM stays in dcache_controller.

Verification
REQ-035 Cold load 0x0000_0040 with refill line {4,3,2,1}: CacheStall=1 through REFILL, mem_addr=0x40, mem_we=0; after mem_ready, ReadDataM=1, CacheStall=0.
REQ-036 Store 0xDEAD_BEEF to 0x44 after REQ-035, then load 0x44: no stall, ReadDataM=0xDEAD_BEEF, dirty set.
REQ-037 Load 0x0000_0080 (same index 0, different tag) after REQ-036: WRITEBACK with mem_addr=0x40, mem_wdata word1=0xDEAD_BEEF, then REFILL at 0x80.
REQ-038 Memory delays mem_ready 5 cycles: mem_req, mem_addr stable, CacheStall=1 for all waiting cycles.
REQ-039 rst low during REFILL, late mem_ready after release: state IDLE, mem_req=0, load 0x40 misses again.
REQ-040 MemReadM=MemWriteM=1 at hit address 0x48 with data 0x5: treated as store; subsequent load 0x48 returns 0x5.
